// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage memory access unit: FSM states, funct3 codes,
// memory port op codes and the request decoder.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Bit 3 is the read enable; loads and stores share the low three bits.
    typedef enum logic [3:0] {
        OP_IDLE = 4'b0000,
        OP_SB   = 4'b0101,
        OP_SH   = 4'b0110,
        OP_SW   = 4'b0111,
        OP_LB   = 4'b1000,
        OP_LBU  = 4'b1001,
        OP_LH   = 4'b1010,
        OP_LHU  = 4'b1011,
        OP_LW   = 4'b1100
    } mem_op_e;

    typedef struct packed {
        mem_op_e    op;
        logic [2:0] n;
        logic       misaligned;
        logic       illegal;
    } access_t;

    function automatic access_t decode_access(input logic       we,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        access_t d;
        d.op         = OP_IDLE;
        d.n          = 3'd1;
        d.misaligned = 1'b0;
        d.illegal    = 1'b0;
        case (funct3)
            F3_B: begin
                if (we) d.op = OP_SB;
                else    d.op = OP_LB;
            end
            F3_BU: begin
                if (we) d.illegal = 1'b1;
                else    d.op = OP_LBU;
            end
            F3_H, F3_HU: begin
                if (we && funct3 == F3_HU) begin
                    d.illegal = 1'b1;
                end else begin
                    if (we)                 d.op = OP_SH;
                    else if (funct3 == F3_H) d.op = OP_LH;
                    else                    d.op = OP_LHU;
                    if (addr_lo[0]) begin
                        d.misaligned = 1'b1;
                        d.n          = 3'd2;
                        if (we) d.op = OP_SB;
                        else    d.op = OP_LBU;
                    end
                end
            end
            F3_W: begin
                if (we) d.op = OP_SW;
                else    d.op = OP_LW;
                if (addr_lo != 2'b00) begin
                    d.misaligned = 1'b1;
                    d.n          = 3'd4;
                    if (we) d.op = OP_SB;
                    else    d.op = OP_LBU;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Final formatting of a load result; only byte-serial halfword loads need
// extension here, everything else already arrives formatted from memory.
module mem_load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] acc_i,
    input  logic [2:0]  funct3_i,
    input  logic        split_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        rdata_o = acc_i;
        if (split_i) begin
            case (funct3_i)
                F3_H:    rdata_o = {{16{acc_i[15]}}, acc_i[15:0]};
                F3_HU:   rdata_o = {16'd0, acc_i[15:0]};
                default: rdata_o = acc_i;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 32-bit data memory port; handles the one-cycle
// registered read latency and splits misaligned accesses into byte accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_rw_en,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        split_q, split_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] acc_q, acc_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_rw_en_q, mem_rw_en_d;

    access_t     req_dec;
    logic        reject;
    logic [1:0]  idx_inc;
    logic [31:0] addr_inc;
    logic [31:0] ext_rdata;

    assign req_dec  = decode_access(req_we, req_funct3, req_addr[1:0]);
    assign reject   = req_dec.illegal || (req_dec.misaligned && !ALLOW_MISALIGNED);
    assign idx_inc  = idx_q + 2'd1;
    assign addr_inc = base_q + {30'd0, idx_inc};

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        split_d     = split_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        last_d      = last_q;
        acc_d       = acc_q;
        mis_d       = mis_q;
        ill_d       = ill_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rw_en_d = mem_rw_en_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    split_d  = req_dec.misaligned;
                    base_d   = req_addr;
                    wdata_d  = req_wdata;
                    idx_d    = '0;
                    last_d   = 2'(req_dec.n - 3'd1);
                    acc_d    = '0;
                    ill_d    = req_dec.illegal;
                    mis_d    = req_dec.misaligned && !ALLOW_MISALIGNED;
                    if (reject) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_addr_d  = req_addr;
                        mem_rw_en_d = req_dec.op;
                        mem_wdata_d = req_dec.misaligned ? {24'd0, req_wdata[7:0]} : req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    state_d = ST_CAPTURE;
                end else if (idx_q == last_q) begin
                    state_d     = ST_RESP;
                    mem_rw_en_d = '0;
                end else begin
                    idx_d       = idx_inc;
                    mem_addr_d  = addr_inc;
                    mem_wdata_d = {24'd0, wdata_q[{idx_inc, 3'b000} +: 8]};
                end
            end
            ST_CAPTURE: begin
                // Split loads collect one byte per lane; aligned loads take the word.
                if (split_q) acc_d[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
                else         acc_d = mem_rdata;
                if (idx_q != last_q) begin
                    state_d    = ST_ACCESS;
                    idx_d      = idx_inc;
                    mem_addr_d = addr_inc;
                end else begin
                    state_d     = ST_RESP;
                    mem_rw_en_d = '0;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            split_q     <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            mis_q       <= 1'b0;
            ill_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_en_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            split_q     <= split_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            mis_q       <= mis_d;
            ill_q       <= ill_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rw_en_q <= mem_rw_en_d;
        end
    end

    mem_load_extend u_extend (
        .acc_i    (acc_q),
        .funct3_i (funct3_q),
        .split_i  (split_q),
        .rdata_o  (ext_rdata)
    );

    assign req_ready       = (state_q == ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign resp_misaligned = resp_valid && mis_q;
    assign resp_illegal    = resp_valid && ill_q;
    assign resp_rdata      = (resp_valid && !we_q && !mis_q && !ill_q) ? ext_rdata : '0;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_rw_en       = mem_rw_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a byte-array memory model with
// one-cycle registered, formatted reads.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_init = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_misaligned, resp_illegal;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_rw_en;
    logic [31:0] mem_rdata;

    logic        s_req_valid = 1'b0, s_req_we = 1'b0;
    logic [2:0]  s_req_funct3 = '0;
    logic [31:0] s_req_addr = '0, s_req_wdata = '0;
    logic        s_req_ready, s_resp_valid, s_resp_misaligned, s_resp_illegal;
    logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_rw_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .resp_illegal(resp_illegal), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rw_en(mem_rw_en), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_we(s_req_we), .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_misaligned(s_resp_misaligned),
        .resp_illegal(s_resp_illegal), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rw_en(s_mem_rw_en), .mem_rdata(32'd0)
    );

    // Memory model: 1 KiB, word[i] = i after init.
    logic [7:0] mem [0:1023];
    logic [9:0] ma0, ma1, ma2, ma3;
    assign ma0 = mem_addr[9:0];
    assign ma1 = ma0 + 10'd1;
    assign ma2 = ma0 + 10'd2;
    assign ma3 = ma0 + 10'd3;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= (i[1:0] == 2'b00) ? 8'(i >> 2) : 8'h00;
            mem_rdata <= '0;
        end else begin
            case (mem_rw_en)
                4'b0101: mem[ma0] <= mem_wdata[7:0];
                4'b0110: begin mem[ma0] <= mem_wdata[7:0]; mem[ma1] <= mem_wdata[15:8]; end
                4'b0111: begin
                    mem[ma0] <= mem_wdata[7:0];   mem[ma1] <= mem_wdata[15:8];
                    mem[ma2] <= mem_wdata[23:16]; mem[ma3] <= mem_wdata[31:24];
                end
                4'b1000: mem_rdata <= {{24{mem[ma0][7]}}, mem[ma0]};
                4'b1001: mem_rdata <= {24'd0, mem[ma0]};
                4'b1010: mem_rdata <= {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
                4'b1011: mem_rdata <= {16'd0, mem[ma1], mem[ma0]};
                4'b1100: mem_rdata <= {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
                default: ;
            endcase
        end
    end

    // Per-cycle trace of one request; index k = cycles after acceptance.
    int          lat;
    logic [31:0] rd;
    logic        rmis, rill, rv_after;
    logic [3:0]  tr_en   [0:15];
    logic [31:0] tr_addr [0:15];
    logic [31:0] tr_wd   [0:15];
    logic        tr_rdy  [0:15];

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        lat = -1; rd = 'x; rmis = 1'bx; rill = 1'bx; rv_after = 1'bx;
        for (int k = 0; k < 16; k++) begin
            tr_en[k] = 'x; tr_addr[k] = 'x; tr_wd[k] = 'x; tr_rdy[k] = 1'bx;
        end
        for (int k = 1; k < 15 && lat < 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            tr_en[k] = mem_rw_en; tr_addr[k] = mem_addr; tr_wd[k] = mem_wdata; tr_rdy[k] = req_ready;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; rmis = resp_misaligned; rill = resp_illegal;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            tr_rdy[lat+1] = req_ready; tr_en[lat+1] = mem_rw_en; rv_after = resp_valid;
        end
    endtask

    task automatic test_reset;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (mem_rw_en !== 4'b0000) begin errors++; $display("FAIL reset_rw_en got %b want 0000", mem_rw_en); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        checks++; if ({resp_misaligned, resp_illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {resp_misaligned, resp_illegal}); end
    endtask

    task automatic test_aligned_load;
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h00000040) begin errors++; $display("FAIL lw_rdata got %h want 00000040", rd); end
        checks++; if (tr_en[1] !== 4'b1100 || tr_en[2] !== 4'b1100) begin errors++; $display("FAIL lw_rw_en got %b %b want 1100 1100", tr_en[1], tr_en[2]); end
        checks++; if (tr_addr[1] !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", tr_addr[1]); end
        checks++; if (tr_en[3] !== 4'b0000) begin errors++; $display("FAIL lw_rw_en_resp got %b want 0000", tr_en[3]); end
        checks++; if (tr_rdy[1] !== 1'b0 || tr_rdy[4] !== 1'b1) begin errors++; $display("FAIL lw_ready got %b %b want 0 1", tr_rdy[1], tr_rdy[4]); end
        checks++; if (rv_after !== 1'b0) begin errors++; $display("FAIL lw_resp_pulse got %b want 0", rv_after); end
    endtask

    task automatic test_split_load;
        run_req(1'b0, 3'b010, 32'h102, 32'h0);
        checks++; if (lat !== 9) begin errors++; $display("FAIL slw_latency got %0d want 9", lat); end
        checks++; if (rd !== 32'h00410000) begin errors++; $display("FAIL slw_rdata got %h want 00410000", rd); end
        checks++; if (tr_addr[1] !== 32'h102 || tr_addr[3] !== 32'h103 || tr_addr[5] !== 32'h104 || tr_addr[7] !== 32'h105)
            begin errors++; $display("FAIL slw_addrs got %h %h %h %h want 102 103 104 105", tr_addr[1], tr_addr[3], tr_addr[5], tr_addr[7]); end
        checks++; if (tr_en[1] !== 4'b1001 || tr_en[8] !== 4'b1001 || tr_addr[8] !== 32'h105)
            begin errors++; $display("FAIL slw_op got %b %b %h want 1001 1001 105", tr_en[1], tr_en[8], tr_addr[8]); end
        run_req(1'b0, 3'b001, 32'h103, 32'h0);
        checks++; if (lat !== 5 || rd !== 32'h00004100) begin errors++; $display("FAIL slh_pos got lat %0d %h want lat 5 00004100", lat, rd); end
        run_req(1'b0, 3'b001, 32'h1FF, 32'h0);
        checks++; if (rd !== 32'hFFFF8000) begin errors++; $display("FAIL slh_neg got %h want ffff8000", rd); end
        run_req(1'b0, 3'b101, 32'h1FF, 32'h0);
        checks++; if (rd !== 32'h00008000) begin errors++; $display("FAIL slhu got %h want 00008000", rd); end
    endtask

    task automatic test_byte_access;
        run_req(1'b1, 3'b000, 32'h103, 32'h000000AB);
        checks++; if (lat !== 2 || rd !== 32'd0) begin errors++; $display("FAIL sb_resp got lat %0d %h want lat 2 0", lat, rd); end
        checks++; if (tr_en[1] !== 4'b0101 || tr_en[2] !== 4'b0000) begin errors++; $display("FAIL sb_rw_en got %b %b want 0101 0000", tr_en[1], tr_en[2]); end
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (rd !== 32'hAB000040) begin errors++; $display("FAIL sb_readback got %h want ab000040", rd); end
        run_req(1'b1, 3'b000, 32'h201, 32'h000000F5);
        run_req(1'b0, 3'b000, 32'h201, 32'h0);
        checks++; if (rd !== 32'hFFFFFFF5) begin errors++; $display("FAIL lb got %h want fffffff5", rd); end
        run_req(1'b0, 3'b100, 32'h201, 32'h0);
        checks++; if (rd !== 32'h000000F5) begin errors++; $display("FAIL lbu got %h want 000000f5", rd); end
    endtask

    task automatic test_split_store;
        run_req(1'b1, 3'b010, 32'h201, 32'hDDCCBBAA);
        checks++; if (lat !== 5) begin errors++; $display("FAIL ssw_latency got %0d want 5", lat); end
        checks++; if (tr_wd[1][7:0] !== 8'hAA || tr_wd[2][7:0] !== 8'hBB || tr_wd[3][7:0] !== 8'hCC || tr_wd[4][7:0] !== 8'hDD)
            begin errors++; $display("FAIL ssw_bytes got %h %h %h %h want aa bb cc dd", tr_wd[1], tr_wd[2], tr_wd[3], tr_wd[4]); end
        checks++; if (tr_en[4] !== 4'b0101 || tr_addr[4] !== 32'h204 || tr_en[5] !== 4'b0000)
            begin errors++; $display("FAIL ssw_ctrl got %b %h %b want 0101 204 0000", tr_en[4], tr_addr[4], tr_en[5]); end
        run_req(1'b0, 3'b010, 32'h200, 32'h0);
        checks++; if (rd !== 32'hCCBBAA80) begin errors++; $display("FAIL ssw_word0 got %h want ccbbaa80", rd); end
        run_req(1'b0, 3'b010, 32'h204, 32'h0);
        checks++; if (rd !== 32'h000000DD) begin errors++; $display("FAIL ssw_word1 got %h want 000000dd", rd); end
        run_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h00001234);
        checks++; if (lat !== 3 || tr_addr[1] !== 32'hFFFFFFFF || tr_addr[2] !== 32'h0 || tr_wd[2] !== 32'h12)
            begin errors++; $display("FAIL ssh_wrap got lat %0d %h %h %h want 3 ffffffff 0 12", lat, tr_addr[1], tr_addr[2], tr_wd[2]); end
    endtask

    task automatic test_reset_abort;
        logic seen;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h201; req_wdata = 32'h44332211;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_rw_en !== 4'b0101 || mem_addr !== 32'h203) begin errors++; $display("FAIL abort_pre got %b %h want 0101 203", mem_rw_en, mem_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_rw_en !== 4'b0000 || resp_valid !== 1'b0) begin errors++; $display("FAIL abort_now got %b %b want 0000 0", mem_rw_en, resp_valid); end
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin @(negedge clk); seen = seen | resp_valid; end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin @(negedge clk); seen = seen | resp_valid; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resp got %b want 0", seen); end
        run_req(1'b0, 3'b010, 32'h200, 32'h0);
        checks++; if (rd !== 32'hCC221180) begin errors++; $display("FAIL abort_word0 got %h want cc221180", rd); end
        run_req(1'b0, 3'b010, 32'h204, 32'h0);
        checks++; if (rd !== 32'h000000DD) begin errors++; $display("FAIL abort_word1 got %h want 000000dd", rd); end
    endtask

    task automatic test_errors;
        run_req(1'b0, 3'b011, 32'h100, 32'h0);
        checks++; if (lat !== 1 || rill !== 1'b1 || rmis !== 1'b0 || rd !== 32'd0)
            begin errors++; $display("FAIL illegal_load got lat %0d ill %b mis %b %h want 1 1 0 0", lat, rill, rmis, rd); end
        checks++; if (tr_en[1] !== 4'b0000 || tr_rdy[2] !== 1'b1) begin errors++; $display("FAIL illegal_noaccess got %b %b want 0000 1", tr_en[1], tr_rdy[2]); end
        s_req_valid = 1'b1; s_req_we = 1'b0; s_req_funct3 = 3'b010; s_req_addr = 32'h101;
        @(negedge clk); s_req_valid = 1'b0;
        checks++; if (s_resp_valid !== 1'b1 || s_resp_misaligned !== 1'b1 || s_resp_illegal !== 1'b0 || s_resp_rdata !== 32'd0)
            begin errors++; $display("FAIL strict_mis got v %b m %b i %b %h want 1 1 0 0", s_resp_valid, s_resp_misaligned, s_resp_illegal, s_resp_rdata); end
        checks++; if (s_mem_rw_en !== 4'b0000) begin errors++; $display("FAIL strict_mis_noaccess got %b want 0000", s_mem_rw_en); end
        @(negedge clk);
        checks++; if (s_resp_valid !== 1'b0 || s_req_ready !== 1'b1 || s_mem_rw_en !== 4'b0000)
            begin errors++; $display("FAIL strict_idle got v %b r %b %b want 0 1 0000", s_resp_valid, s_req_ready, s_mem_rw_en); end
        s_req_valid = 1'b1; s_req_we = 1'b1; s_req_funct3 = 3'b100; s_req_addr = 32'h100;
        @(negedge clk); s_req_valid = 1'b0;
        checks++; if (s_resp_valid !== 1'b1 || s_resp_illegal !== 1'b1 || s_resp_misaligned !== 1'b0)
            begin errors++; $display("FAIL strict_ill got v %b i %b m %b want 1 1 0", s_resp_valid, s_resp_illegal, s_resp_misaligned); end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        test_aligned_load();
        test_split_load();
        test_byte_access();
        test_split_store();
        test_reset_abort();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage initiator that drives the 32-bit data memory port: read_write_en-style control, address and write data. It accepts one load/store request at a time from the pipeline and handles the memory's one-cycle registered read latency. Misaligned halfword/word accesses are split into byte-serial accesses, and loads return a formatted, sign/zero-extended 32-bit result.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned LH/LHU/LW/SH/SW into byte accesses; 0 = reject them with resp_misaligned.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present; accepted when req_valid && req_ready.
req_ready  out  1  high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, low bytes significant.
resp_valid  out  1  one-cycle completion pulse for every accepted request. There is no backpressure.
resp_rdata  out  32  load result, valid with resp_valid. 0 for stores and errors.
resp_misaligned  out  1  with resp_valid: misaligned access rejected (ALLOW_MISALIGNED=0).
resp_illegal  out  1  with resp_valid: illegal funct3 (011, 110, 111, or store with 100/101).
mem_addr  out  32  memory byte address, registered.
mem_wdata  out  32  memory write data, registered. Byte/half data is in the low bits.
mem_rw_en  out  4  [3] = read enable; [2:0]: loads 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; stores 101 SB, 110 SH, 111 SW; 0000 = idle.
mem_rdata  in  32  formatted memory data. Valid the cycle after a read is issued while mem_addr/mem_rw_en are held.

Behaviour:
- Reset (async, immediate): state IDLE. mem_addr, mem_wdata, resp_rdata = 0. mem_rw_en = 4'b0000. resp_valid, resp_misaligned, resp_illegal = 0.
- Reset mid-operation aborts immediately. Bytes already written stay written; the remaining bytes are not written and no response is issued.
- States: IDLE, ACCESS, CAPTURE, RESP.
- Request accepted in cycle T: fields latched; byte index i = 0; N set.
  - Aligned: N = 1, native op.
  - Misaligned: N = 2 (H) or 4 (W), each access a byte op (LBU / SB).
  - Aligned means H: addr[0] = 0; W: addr[1:0] = 0.
- Errors: illegal funct3, or misaligned with ALLOW_MISALIGNED=0, go IDLE -> RESP. resp_valid pulses in T+1 with the flag set and no memory access (mem_rw_en stays 0000).
- ACCESS: mem_addr = base + i, 32-bit wrap-around. mem_rw_en = op code. For split stores, mem_wdata = req_wdata[8i+7:8i].
  - Store: i++, stay in ACCESS until i = N-1, then go RESP with mem_rw_en back to 0000.
  - Load: go CAPTURE.
- CAPTURE (loads): mem_addr/mem_rw_en held unchanged. mem_rdata byte (split) or word (aligned) latched into lane i of the accumulator.
  - If i < N-1: i++, return to ACCESS.
  - Else go RESP.
- RESP: resp_valid = 1 for exactly one cycle. Split LH is sign-extended from accumulator bit 15; LHU is zero-extended; split LW passes through. mem_rw_en = 0000. Next state IDLE, so req_ready is high in the following cycle.
- Latency from acceptance T to resp_valid:
  - Aligned load: T+3.
  - Aligned store: T+2.
  - Split load: T+1+2N.
  - Split store: T+1+N.
- mem_rw_en is never nonzero outside ACCESS/CAPTURE. No request is accepted while not in IDLE.

Decomposition:
- Package mem_access_pkg: state enum, funct3 constants, the 4-bit mem_rw_en op codes (LB..SW, IDLE), and a function mapping (we, funct3) to the op code and N.
- Sub-module mem_load_extend: combinational sign/zero extension of the accumulated split-load value.

Test Plan:
- Memory initialised word[i] = i; LW 0x100 at T -> resp_valid T+3, resp_rdata 0x00000040, mem_rw_en 4'b1100 in T+1..T+2.
- SB 0xAB to 0x103 (resp at T+2), then LW 0x100 -> 0xAB000040.
- SB 0xF5 to 0x201, then LB 0x201 -> 0xFFFFFFF5, then LBU 0x201 -> 0x000000F5.
- Misaligned LW 0x102 -> four LBU accesses at 0x102..0x105, resp at T+9, rdata 0x00410000.
- Misaligned LH 0x103 -> rdata 0x00004100.
- Misaligned SW 0xDDCCBBAA to 0x201:
  - Without reset: four SB accesses, LW 0x200 -> 0xCCBBAA80 and LW 0x204 -> 0x000000DD.
  - Repeated with rst_n low after two bytes: 0x201 = AA, 0x202 = BB, 0x203/0x204 unchanged, mem_rw_en 0000 immediately, no resp_valid.
- ALLOW_MISALIGNED=0:
  - LW 0x101 -> resp_valid T+1, resp_misaligned 1, rdata 0, no memory access.
  - Store with funct3 100 -> resp_illegal 1.
